// File: rtl/arp_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : arp_decode
//  Description : Streaming ARP payload decoder. Consumes one payload nibble
//                per cycle (network byte order, low nibble of each byte
//                first), checks the fixed header fields and the target
//                protocol address on the fly into a sticky mismatch flag,
//                and captures SHA/SPA into shadow registers. On the cycle
//                after the 56th nibble it either publishes sha/spa/is_reply
//                with an arp_valid pulse or raises a drop pulse. Trailing
//                Ethernet padding/FCS is swallowed until ivalid falls.
//  Options     : ARP_REPLY_ACCEPT_EN - when defined, OPER=2 (reply) is also
//                accepted and reported through is_reply; when undefined only
//                requests (OPER=1) pass and is_reply is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module arp_decode #(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ivalid,
    input  logic [3:0]  din,
    output logic        arp_valid,
    output logic        drop,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic        is_reply
);

    // ------------------------------------------------------------------------
    // Parser states
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PARSE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // Index of the final ARP payload nibble (28 bytes * 2 - 1)
    localparam logic [5:0] c_LAST_NIB = 6'd55;
    // Nibble carrying the low half of the OPER low byte
    localparam logic [5:0] c_OPER_NIB = 6'd14;

    // Own MAC is carried for reference only; it takes part in no check.
    logic w_unused_mac;
    assign w_unused_mac = ^MAC_ADDR;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;        // index of the nibble currently on din
    logic        r_mis;        // sticky: some checked nibble was wrong
    logic        r_armed;      // ivalid has been seen low since reset
    logic [3:0]  r_nib_lo;     // low nibble of the byte being assembled
    logic [47:0] r_sha_sh;     // SHA shadow, filled MSB byte first
    logic [31:0] r_spa_sh;     // SPA shadow, filled MSB byte first

    // ------------------------------------------------------------------------
    // Per-nibble field check
    // ------------------------------------------------------------------------
    logic [4:0] w_byte;
    logic [7:0] w_exp_byte;
    logic [3:0] w_exp_nib;
    logic       w_chk;
    logic       w_nib_bad;
    logic       w_mis_next;
    logic       w_in_sha;
    logic       w_in_spa;

    assign w_byte   = r_cnt[5:1];
    assign w_in_sha = (w_byte >= 5'd8)  && (w_byte <= 5'd13);
    assign w_in_spa = (w_byte >= 5'd14) && (w_byte <= 5'd17);

    // Expected value of the current nibble; bytes outside the checked
    // fields (SHA, SPA, THA) are don't-care.
    always_comb begin
        w_chk      = 1'b1;
        w_exp_byte = 8'h00;
        case (w_byte)
            5'd0:    w_exp_byte = 8'h00;           // HTYPE hi
            5'd1:    w_exp_byte = 8'h01;           // HTYPE lo
            5'd2:    w_exp_byte = 8'h08;           // PTYPE hi
            5'd3:    w_exp_byte = 8'h00;           // PTYPE lo
            5'd4:    w_exp_byte = 8'h06;           // HLEN
            5'd5:    w_exp_byte = 8'h04;           // PLEN
            5'd6:    w_exp_byte = 8'h00;           // OPER hi
            5'd7:    w_exp_byte = 8'h01;           // OPER lo
            5'd24:   w_exp_byte = IP_ADDR[31:24];  // TPA
            5'd25:   w_exp_byte = IP_ADDR[23:16];
            5'd26:   w_exp_byte = IP_ADDR[15:8];
            5'd27:   w_exp_byte = IP_ADDR[7:0];
            default: w_chk      = 1'b0;
        endcase
        w_exp_nib = r_cnt[0] ? w_exp_byte[7:4] : w_exp_byte[3:0];
        w_nib_bad = w_chk && (din != w_exp_nib);
`ifdef ARP_REPLY_ACCEPT_EN
        // OPER low byte may be 1 (request) or 2 (reply)
        if (r_cnt == c_OPER_NIB) begin
            w_nib_bad = (din != 4'h1) && (din != 4'h2);
        end
`endif
    end

    // Mismatch including the nibble being accepted this cycle, so the
    // final TPA nibble is part of the accept decision.
    assign w_mis_next = r_mis | w_nib_bad;

    // ------------------------------------------------------------------------
    // Control FSM, nibble counter, mismatch flag and result outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 6'd0;
            r_mis     <= 1'b0;
            r_armed   <= 1'b0;
            arp_valid <= 1'b0;
            drop      <= 1'b0;
            sha       <= 48'h0;
            spa       <= 32'h0;
        end else begin
            arp_valid <= 1'b0;
            drop      <= 1'b0;
            // A new packet needs ivalid to have been low at least once,
            // which also covers release from reset in the middle of a frame.
            if (!ivalid) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (ivalid && r_armed) begin
                        r_state <= c_PARSE;
                        r_cnt   <= 6'd1;
                        r_mis   <= w_nib_bad;
                    end
                end
                c_PARSE: begin
                    if (!ivalid) begin
                        // Truncated payload: reject, keep published fields
                        drop    <= 1'b1;
                        r_state <= c_IDLE;
                        r_cnt   <= 6'd0;
                        r_mis   <= 1'b0;
                    end else if (r_cnt == c_LAST_NIB) begin
                        r_state <= c_DRAIN;
                        r_cnt   <= 6'd0;
                        r_mis   <= 1'b0;
                        if (w_mis_next) begin
                            drop <= 1'b1;
                        end else begin
                            arp_valid <= 1'b1;
                            sha       <= r_sha_sh;
                            spa       <= r_spa_sh;
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        r_mis <= w_mis_next;
                    end
                end
                c_DRAIN: begin
                    // Padding and FCS are ignored until the frame ends
                    if (!ivalid) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 6'd0;
                    r_mis   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Shadow capture of SHA and SPA, one byte per nibble pair
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nib_lo <= 4'h0;
            r_sha_sh <= 48'h0;
            r_spa_sh <= 32'h0;
        end else if ((r_state == c_PARSE) && ivalid) begin
            r_nib_lo <= din;
            if (r_cnt[0] && w_in_sha) begin
                r_sha_sh <= {r_sha_sh[39:0], din, r_nib_lo};
            end
            if (r_cnt[0] && w_in_spa) begin
                r_spa_sh <= {r_spa_sh[23:0], din, r_nib_lo};
            end
        end
    end

`ifdef ARP_REPLY_ACCEPT_EN
    logic r_rep_sh;

    // Remember whether OPER announced a reply and publish it on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_sh <= 1'b0;
            is_reply <= 1'b0;
        end else begin
            if ((r_state == c_PARSE) && ivalid && (r_cnt == c_OPER_NIB)) begin
                r_rep_sh <= (din == 4'h2);
            end
            if ((r_state == c_PARSE) && ivalid && (r_cnt == c_LAST_NIB) && !w_mis_next) begin
                is_reply <= r_rep_sh;
            end
        end
    end
`else
    // Replies are never accepted in this build
    assign is_reply = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arp_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_arp_decode
//  Description : Scoreboard bench for arp_decode. Packets are built as byte
//                arrays; a field-level model decides accept/drop and the
//                cycle of the pulse, pushes the expectation, and a monitor
//                pops and compares whenever the DUT pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_decode;

    localparam logic [31:0] c_IP = 32'hC0A80102;
`ifdef ARP_REPLY_ACCEPT_EN
    localparam bit c_REPLY_EN = 1'b1;
`else
    localparam bit c_REPLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivalid = 1'b0;
    logic [3:0]  din = 4'h0;
    logic        arp_valid;
    logic        drop;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        is_reply;

    arp_decode #(
        .MAC_ADDR (48'h0A0B0C0D0E0F),
        .IP_ADDR  (c_IP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid    (ivalid),
        .din       (din),
        .arp_valid (arp_valid),
        .drop      (drop),
        .sha       (sha),
        .spa       (spa),
        .is_reply  (is_reply)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          acc;
        logic [47:0] sha;
        logic [31:0] spa;
        bit          rep;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [47:0] m_sha  = '0;
    logic [31:0] m_spa  = '0;
    bit          m_rep  = 1'b0;
    logic [7:0]  pkt[28];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (arp_valid && drop) begin
                check("both_pulses", {arp_valid, drop}, 2'b00);
            end else if (arp_valid || drop) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", {arp_valid, drop}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_kind", arp_valid, e.acc);
                    check("pulse_cycle", cyc, e.cyc);
                    check("sha", sha, e.sha);
                    check("spa", spa, e.spa);
                    check("is_reply", is_reply, e.rep);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                check("missing_pulse_at", cyc, e.cyc);
            end
        end
    end

    task automatic build(input logic [15:0] op, input logic [47:0] s,
                         input logic [31:0] p, input logic [31:0] t);
        pkt[0] = 8'h00; pkt[1] = 8'h01; pkt[2] = 8'h08; pkt[3] = 8'h00;
        pkt[4] = 8'h06; pkt[5] = 8'h04; pkt[6] = op[15:8]; pkt[7] = op[7:0];
        for (int i = 0; i < 6; i++) pkt[8 + i]  = s[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) pkt[14 + i] = p[31 - 8*i -: 8];
        for (int i = 0; i < 6; i++) pkt[18 + i] = 8'($urandom);
        for (int i = 0; i < 4; i++) pkt[24 + i] = t[31 - 8*i -: 8];
    endtask

    // Field-level acceptance rule
    function automatic bit model_ok();
        logic [15:0] ht, pt, op;
        logic [31:0] tpa;
        ht  = {pkt[0], pkt[1]};
        pt  = {pkt[2], pkt[3]};
        op  = {pkt[6], pkt[7]};
        tpa = {pkt[24], pkt[25], pkt[26], pkt[27]};
        return (ht == 16'h0001) && (pt == 16'h0800) && (pkt[4] == 8'h06) &&
               (pkt[5] == 8'h04) && ((op == 16'h0001) || (c_REPLY_EN && op == 16'h0002)) &&
               (tpa == c_IP);
    endfunction

    task automatic push_expect(input int c0, input int nib_high);
        exp_t e;
        if (nib_high < 56) begin
            e.acc = 1'b0;
            e.cyc = c0 + nib_high + 1;
        end else begin
            e.cyc = c0 + 56;
            e.acc = model_ok();
            if (e.acc) begin
                m_sha = {pkt[8], pkt[9], pkt[10], pkt[11], pkt[12], pkt[13]};
                m_spa = {pkt[14], pkt[15], pkt[16], pkt[17]};
                m_rep = ({pkt[6], pkt[7]} == 16'h0002);
            end
        end
        e.sha = m_sha;
        e.spa = m_spa;
        e.rep = m_rep;
        sbq.push_back(e);
    endtask

    // Stream pkt (plus random padding past nibble 55) for nib_high cycles
    task automatic send(input int nib_high, input int gap);
        for (int i = 0; i < nib_high; i++) begin
            @(posedge clk); #1;
            if (i == 0) push_expect(cyc, nib_high);
            ivalid = 1'b1;
            if (i < 56) din = i[0] ? pkt[i/2][7:4] : pkt[i/2][3:0];
            else        din = 4'($urandom);
        end
        @(posedge clk); #1;
        ivalid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind, idx, pad;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {arp_valid, drop, sha, spa, is_reply}, '0);

        // Reference request
        build(16'h0001, 48'h021122334455, 32'hC0A80105, 32'hC0A80102);
        send(56, 3);
        // Wrong target address
        build(16'h0001, 48'h021122334455, 32'hC0A80105, 32'hC0A80109);
        send(56, 3);
        // Valid request with 36 padding nibbles
        build(16'h0001, 48'hA1B2C3D4E5F6, 32'h0A000001, c_IP);
        send(56 + 36, 3);
        // Truncation after nibble 30, then a good packet
        build(16'h0001, 48'h112233445566, 32'h0A000002, c_IP);
        send(31, 3);
        build(16'h0001, 48'h665544332211, 32'h0A000003, c_IP);
        send(56, 3);
        // Reply
        build(16'h0002, 48'h0000DEADBEEF, 32'h0A000004, c_IP);
        send(56, 3);

        // Reset in the middle of a packet, ivalid held high across release
        build(16'h0001, 48'h123456789ABC, 32'h0A000005, c_IP);
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk); #1;
            ivalid = 1'b1;
            din = i[0] ? pkt[i/2][7:4] : pkt[i/2][3:0];
        end
        #3 rst = 1'b1;
        #1;
        check("async_reset_outputs", {arp_valid, drop, sha, spa, is_reply}, '0);
        m_sha = '0; m_spa = '0; m_rep = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            din = (i < 56) ? (i[0] ? pkt[i/2][7:4] : pkt[i/2][3:0]) : 4'h0;
            @(posedge clk); #1;
        end
        ivalid = 1'b0;
        repeat (3) @(posedge clk);
        check("post_reset_held_outputs", {arp_valid, drop, sha, spa, is_reply}, '0);
        send(56, 3);

        // Randomised mix
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 8);
            build(16'h0001, {16'($urandom), 32'($urandom)}, 32'($urandom), c_IP);
            pad = $urandom_range(0, 40);
            case (kind)
                2: pkt[24 + $urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
                3: pkt[$urandom_range(0, 1)]      ^= 8'(1 << $urandom_range(0, 7));
                4: pkt[$urandom_range(2, 3)]      ^= 8'(1 << $urandom_range(0, 7));
                5: pkt[$urandom_range(4, 5)]      ^= 8'(1 << $urandom_range(0, 7));
                6: pkt[7] = 8'h02;
                7: begin idx = $urandom_range(6, 7); pkt[idx] = 8'($urandom_range(0, 15)); end
                default: ;
            endcase
            if (kind == 8) send($urandom_range(1, 55), $urandom_range(2, 5));
            else           send(56 + pad, $urandom_range(2, 5));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arp_decode.md
ARP_DECODE -- requirements
Module: arp_decode

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h0: own hardware address, informational only, not compared.
REQ-002 SHALL have parameter IP_ADDR, default 32'h0: own IPv4 address, compared against TPA.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ivalid, input, 1 bit: din carries a payload nibble this cycle; high for the whole ARP payload, low between frames.
REQ-006 SHALL have port din, input, 4 bits: payload nibble; bytes in network order, low nibble of each byte first.
REQ-007 SHALL have port arp_valid, output, 1 bit: one-cycle pulse when an accepted packet's sha/spa/is_reply are valid.
REQ-008 SHALL have port drop, output, 1 bit: one-cycle pulse when a packet is rejected or truncated.
REQ-009 SHALL have port sha, output, 48 bits: sender hardware address of the last accepted packet.
REQ-010 SHALL have port spa, output, 32 bits: sender protocol address of the last accepted packet.
REQ-011 SHALL have port is_reply, output, 1 bit: last accepted packet had OPER=2.

Function
REQ-012 SHALL number accepted nibbles n=0..55 with a 6-bit counter; nibble n maps to byte n/2, low nibble when n is even.
REQ-013 SHALL check the following byte fields: HTYPE bytes 0-1 = 0x0001; PTYPE bytes 2-3 = 0x0800; HLEN byte 4 = 0x06; PLEN byte 5 = 0x04; OPER bytes 6-7 = 0x0001; TPA bytes 24-27 = IP_ADDR.
REQ-014 SHALL ignore THA (bytes 18-23).
REQ-015 SHALL perform checks incrementally per nibble into a sticky mismatch flag, with no full-packet buffer.
REQ-016 SHALL shift SHA (bytes 8-13) and SPA (bytes 14-17) into shadow registers; sha/spa SHALL update from the shadows only on accept and otherwise hold.
REQ-017 SHALL implement states IDLE, PARSE, DRAIN.
- IDLE -> PARSE when ivalid=1; that nibble is n=0.
- PARSE -> DRAIN when n=55 is accepted.
- DRAIN -> IDLE when ivalid=0.
REQ-018 SHALL, on the cycle after n=55 is accepted: pulse arp_valid if mismatch is clear (sha/spa/is_reply updated in the same cycle), else pulse drop.
REQ-019 SHALL, in DRAIN, ignore all nibbles (Ethernet padding/FCS) and raise no further pulses.
REQ-020 SHALL, if ivalid falls in PARSE before n=55, pulse drop on the next cycle, return to IDLE, and leave sha/spa unchanged.
REQ-021 SHALL treat ivalid low on the cycle n=55 would arrive as truncation (REQ-020).
REQ-022 SHALL require a fresh ivalid rising edge to start a new packet: a packet with ivalid continuously high is never re-parsed.
REQ-023 SHALL never assert arp_valid and drop in the same cycle.

Reset
REQ-024 SHALL, on rst=1, immediately and asynchronously clear: state=IDLE, counter=0, mismatch=0, arp_valid=0, drop=0, sha=0, spa=0, is_reply=0, shadows=0.
REQ-025 SHALL abandon any packet in progress when reset is asserted mid-packet, without a drop pulse.
REQ-026 SHALL, after release with ivalid already high, wait for ivalid low before parsing.

Configuration
REQ-027 SHALL honour macro ARP_REPLY_ACCEPT_EN.
- Defined: OPER 0x0002 also passes the check; is_reply=1 on such accepts, 0 for OPER=1.
- Undefined: only OPER=1 passes; is_reply is tied to 0.

Verification
REQ-028 SHALL verify: IP_ADDR=C0A80102; request SHA 02:11:22:33:44:55, SPA C0A80105, TPA C0A80102 -> arp_valid pulse at cycle 57 after first nibble; sha=021122334455, spa=C0A80105, is_reply=0.
REQ-029 SHALL verify: same request with TPA C0A80109 -> drop pulse only; sha/spa retain previous values.
REQ-030 SHALL verify: valid request followed by 36 padding nibbles before ivalid low -> exactly one arp_valid pulse, none in DRAIN.
REQ-031 SHALL verify: ivalid falls after nibble 30 -> drop pulse next cycle, state IDLE; a following valid request is accepted.
REQ-032 SHALL verify: OPER=0x0002 with TPA match -> arp_valid with is_reply=1 when ARP_REPLY_ACCEPT_EN is defined, drop when undefined.
REQ-033 SHALL verify: rst asserted at nibble 20 while ivalid stays high -> outputs zero immediately; no pulse; next packet after an ivalid low gap is accepted.
